// File: rtl/uart_baud_tick_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_baud_tick_gen
// Description : Baud timing generator for the UART. A fractional divider
//               produces a one-cycle oversample tick in the i_Clk domain;
//               a TX bit tick and a re-alignable RX mid-bit sample strobe
//               are derived from it.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick_gen #(
  parameter int CLK_HZ         = 100000000,
  parameter int OVERSAMPLE     = 16,
  parameter int DIV_INT_W      = 16,
  parameter int DIV_FRAC_W     = 4,
  parameter int RESET_DIV_INT  = CLK_HZ / (9600 * OVERSAMPLE),
  parameter int RESET_DIV_FRAC = 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_En,
  input  logic [DIV_INT_W-1:0]  i_Div_Int,
  input  logic [DIV_FRAC_W-1:0] i_Div_Frac,
  input  logic                  i_Div_Load,
  input  logic                  i_Rx_Sync,
  output logic                  o_Os_Tick,
  output logic                  o_Tx_Tick,
  output logic                  o_Rx_Sample,
  output logic                  o_Div_Pending
);

  localparam int c_PH_W = $clog2(OVERSAMPLE);

  localparam logic [c_PH_W-1:0]     c_PH_ONE      = c_PH_W'(1);
  localparam logic [c_PH_W-1:0]     c_TX_LAST     = c_PH_W'(OVERSAMPLE - 1);
  localparam logic [c_PH_W-1:0]     c_RX_MID      = c_PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [DIV_INT_W-1:0]  c_CNT_ONE     = DIV_INT_W'(1);
  localparam logic [DIV_INT_W-1:0]  c_DIV_MIN     = DIV_INT_W'(2);
  localparam logic [DIV_INT_W-1:0]  c_RST_INT_RAW = DIV_INT_W'(RESET_DIV_INT);
  localparam logic [DIV_INT_W-1:0]  c_RST_INT     = (c_RST_INT_RAW < c_DIV_MIN) ? c_DIV_MIN : c_RST_INT_RAW;
  localparam logic [DIV_FRAC_W-1:0] c_RST_FRAC    = DIV_FRAC_W'(RESET_DIV_FRAC);

  // A divisor below 2 would make the down-counter reload to 0 and tick
  // every cycle, so every applied integer divisor is floored at 2.
  function automatic logic [DIV_INT_W-1:0] f_clamp_div(input logic [DIV_INT_W-1:0] v);
    f_clamp_div = (v < c_DIV_MIN) ? c_DIV_MIN : v;
  endfunction

  logic [DIV_INT_W-1:0]  r_div_int;
  logic [DIV_FRAC_W-1:0] r_div_frac;
  logic [DIV_INT_W-1:0]  r_pend_int;
  logic [DIV_FRAC_W-1:0] r_pend_frac;
  logic                  r_pend;
  logic [DIV_INT_W-1:0]  r_cnt;
  logic [DIV_FRAC_W-1:0] r_acc;
  logic [c_PH_W-1:0]     r_tx_ph;
  logic [c_PH_W-1:0]     r_rx_ph;

  logic                  w_os_tick;
  logic                  w_apply;
  logic [DIV_FRAC_W:0]   w_acc_sum;
  logic [DIV_INT_W-1:0]  w_div_int_nxt;
  logic [DIV_FRAC_W-1:0] w_div_frac_nxt;

  // The tick is gated by i_En directly so that dropping the enable kills
  // the current period in the same cycle, with no trailing tick.
  assign w_os_tick = i_En & (r_cnt == '0);
  assign w_apply   = w_os_tick & r_pend;
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_div_frac};

  // Divisor that becomes active at the next edge: immediate while disabled,
  // otherwise only at a tick that finds a pending value.
  always_comb begin
    w_div_int_nxt  = r_div_int;
    w_div_frac_nxt = r_div_frac;
    if (!i_En) begin
      if (i_Div_Load) begin
        w_div_int_nxt  = f_clamp_div(i_Div_Int);
        w_div_frac_nxt = i_Div_Frac;
      end else if (r_pend) begin
        w_div_int_nxt  = f_clamp_div(r_pend_int);
        w_div_frac_nxt = r_pend_frac;
      end
    end else if (w_apply) begin
      w_div_int_nxt  = f_clamp_div(r_pend_int);
      w_div_frac_nxt = r_pend_frac;
    end
  end

  // Active divisor register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_div_int  <= c_RST_INT;
      r_div_frac <= c_RST_FRAC;
    end else begin
      r_div_int  <= w_div_int_nxt;
      r_div_frac <= w_div_frac_nxt;
    end
  end

  // Pending divisor capture; a load at a tick edge stays pending for the
  // following tick because the tick itself uses the value already held.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_pend      <= 1'b0;
      r_pend_int  <= '0;
      r_pend_frac <= '0;
    end else if (!i_En) begin
      r_pend      <= 1'b0;
    end else if (i_Div_Load) begin
      r_pend      <= 1'b1;
      r_pend_int  <= i_Div_Int;
      r_pend_frac <= i_Div_Frac;
    end else if (w_apply) begin
      r_pend      <= 1'b0;
    end
  end

  // Period down-counter and fraction accumulator; a carry stretches the
  // following period by one cycle.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_cnt <= c_RST_INT - c_CNT_ONE;
      r_acc <= '0;
    end else if (!i_En) begin
      r_cnt <= w_div_int_nxt - c_CNT_ONE;
      r_acc <= '0;
    end else if (w_os_tick) begin
      if (w_apply) begin
        r_cnt <= w_div_int_nxt - c_CNT_ONE;
        r_acc <= '0;
      end else begin
        r_cnt <= w_acc_sum[DIV_FRAC_W] ? r_div_int : (r_div_int - c_CNT_ONE);
        r_acc <= w_acc_sum[DIV_FRAC_W-1:0];
      end
    end else begin
      r_cnt <= r_cnt - c_CNT_ONE;
    end
  end

  // TX and RX phase counters; both wrap naturally at OVERSAMPLE, and a
  // sync pulse overrides a coincident tick on the RX side.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_tx_ph <= '0;
      r_rx_ph <= '0;
    end else if (!i_En) begin
      r_tx_ph <= '0;
      r_rx_ph <= '0;
    end else begin
      if (w_os_tick) begin
        r_tx_ph <= r_tx_ph + c_PH_ONE;
      end
      if (i_Rx_Sync) begin
        r_rx_ph <= '0;
      end else if (w_os_tick) begin
        r_rx_ph <= r_rx_ph + c_PH_ONE;
      end
    end
  end

  assign o_Os_Tick     = w_os_tick;
  assign o_Tx_Tick     = w_os_tick & (r_tx_ph == c_TX_LAST);
  assign o_Rx_Sample   = w_os_tick & ~i_Rx_Sync & (r_rx_ph == c_RX_MID);
  assign o_Div_Pending = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_tick_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_baud_tick_gen
// Description : Self-checking bench for uart_baud_tick_gen. Expected tick
//               cycles are queued when stimulus is driven and matched
//               against the DUT outputs as they appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_baud_tick_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        load;
  logic        sync;
  logic        os_tick;
  logic        tx_tick;
  logic        rx_sample;
  logic        pend;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int cyc;
    bit tx;
    bit rx;
  } exp_t;

  typedef struct {
    int         di;
    int         df;
    int         base;
    logic [7:0] extra;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];

  uart_baud_tick_gen #(
    .CLK_HZ        (100000000),
    .OVERSAMPLE    (16),
    .DIV_INT_W     (16),
    .DIV_FRAC_W    (4),
    .RESET_DIV_INT (651),
    .RESET_DIV_FRAC(1)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_En         (en),
    .i_Div_Int    (div_int),
    .i_Div_Frac   (div_frac),
    .i_Div_Load   (load),
    .i_Rx_Sync    (sync),
    .o_Os_Tick    (os_tick),
    .o_Tx_Tick    (tx_tick),
    .o_Rx_Sample  (rx_sample),
    .o_Div_Pending(pend)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: match each oversample tick against the queue head.
  always @(negedge clk) begin
    if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL os_missed cyc=%0d expected_tick_cyc=%0d", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (os_tick) begin
      checks++;
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        failures++;
        $display("FAIL os_unexpected cyc=%0d got=1 required=0 next_expected=%0d",
                 cyc, (exp_q.size() == 0) ? -1 : exp_q[0].cyc);
      end else begin
        checks += 2;
        if (tx_tick !== exp_q[0].tx) begin
          failures++;
          $display("FAIL tx_tick cyc=%0d got=%0b required=%0b", cyc, tx_tick, exp_q[0].tx);
        end
        if (rx_sample !== exp_q[0].rx) begin
          failures++;
          $display("FAIL rx_sample cyc=%0d got=%0b required=%0b", cyc, rx_sample, exp_q[0].rx);
        end
        void'(exp_q.pop_front());
      end
    end else if (tx_tick || rx_sample) begin
      checks++;
      failures++;
      $display("FAIL stray_tx_rx cyc=%0d tx=%0b rx=%0b required=0", cyc, tx_tick, rx_sample);
    end
  end

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h required=%h", nm, cyc, got, req);
    end
  endtask

  task automatic push_tick(input int c, input bit t, input bit r);
    exp_t e;
    e.cyc = c;
    e.tx  = t;
    e.rx  = r;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout cyc=%0d left=%0d required=0", cyc, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic goto_cycle(input int c);
    int g = 0;
    while (cyc < c && g < 1000) begin
      step();
      g++;
    end
    checks++;
    if (cyc != c) begin
      failures++;
      $display("FAIL goto_cycle got=%0d required=%0d", cyc, c);
    end
  endtask

  // Load a divisor while disabled, then enable; returns the first enabled cycle.
  task automatic start_run(input int di, input int df, output int e);
    step();
    load     = 1'b1;
    div_int  = 16'(di);
    div_frac = 4'(df);
    step();
    load = 1'b0;
    en   = 1'b1;
    e    = cyc;
    @(negedge clk);
    chk("pend_after_idle_load", {3'b0, pend}, 4'h0);
  endtask

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog cyc=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    int t;
    int c;

    vecs[0] = '{4, 8, 4, 8'h54};
    vecs[1] = '{0, 0, 2, 8'h00};
    vecs[2] = '{1, 0, 2, 8'h00};
    vecs[3] = '{3, 4, 3, 8'h10};
    vecs[4] = '{5, 15, 5, 8'hFC};
    vecs[5] = '{6, 1, 6, 8'h00};

    rst_n    = 1'b0;
    en       = 1'b1;
    load     = 1'b0;
    sync     = 1'b0;
    div_int  = '0;
    div_frac = '0;

    // Reset state with the generator already enabled.
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", {os_tick, tx_tick, rx_sample, pend}, 4'h0);
    end

    // Default divisor 651 + 1/16: one 652-cycle period in sixteen.
    step();
    rst_n = 1'b1;
    e = cyc;
    c = e - 1;
    for (int k = 0; k < 17; k++) begin
      c += (k == 16) ? 652 : 651;
      push_tick(c, k == 15, k == 7);
    end
    wait_drain(12000);
    step();
    en = 1'b0;

    // Table of divisors loaded while idle, with the expected period sequence.
    for (int v = 0; v < 6; v++) begin
      start_run(vecs[v].di, vecs[v].df, e);
      c = e - 1;
      for (int k = 0; k < 8; k++) begin
        c += vecs[v].base + int'(vecs[v].extra[k]);
        push_tick(c, 1'b0, k == 7);
      end
      wait_drain(200);
      step();
      en = 1'b0;
    end

    // Load 7 in the middle of a 4-cycle period; TX phase runs straight on.
    start_run(4, 0, e);
    for (int k = 0; k < 5; k++) push_tick(e + 3 + 4 * k, 1'b0, 1'b0);
    wait_drain(100);
    t = cyc;
    step();
    step();
    load    = 1'b1;
    div_int = 16'd7;
    @(negedge clk);
    chk("pend_load_cycle", {3'b0, pend}, 4'h0);
    step();
    load = 1'b0;
    push_tick(t + 4, 1'b0, 1'b0);
    for (int k = 6; k < 17; k++) push_tick(t + 4 + 7 * (k - 5), k == 15, k == 7);
    @(negedge clk);
    chk("pend_waiting", {3'b0, pend}, 4'h1);
    @(negedge clk);
    chk("pend_at_tick", {3'b0, pend}, 4'h1);
    @(negedge clk);
    chk("pend_after_tick", {3'b0, pend}, 4'h0);
    wait_drain(300);
    step();
    en = 1'b0;

    // Two loads while pending: only the second (12) is applied.
    start_run(4, 0, e);
    push_tick(e + 3, 1'b0, 1'b0);
    push_tick(e + 7, 1'b0, 1'b0);
    wait_drain(100);
    t = cyc;
    step();
    load    = 1'b1;
    div_int = 16'd10;
    step();
    div_int = 16'd12;
    step();
    load = 1'b0;
    push_tick(t + 4, 1'b0, 1'b0);
    push_tick(t + 16, 1'b0, 1'b0);
    push_tick(t + 28, 1'b0, 1'b0);
    @(negedge clk);
    chk("pend_double_load", {3'b0, pend}, 4'h1);
    wait_drain(200);
    step();
    en = 1'b0;

    // RX realignment: sync between ticks 2 and 3, then sync on tick 12.
    start_run(4, 0, e);
    for (int k = 0; k < 22; k++) push_tick(e + 3 + 4 * k, k == 15, (k == 10) || (k == 20));
    goto_cycle(e + 13);
    sync = 1'b1;
    step();
    sync = 1'b0;
    goto_cycle(e + 3 + 4 * 12);
    sync = 1'b1;
    step();
    sync = 1'b0;
    wait_drain(200);
    step();
    en = 1'b0;

    // Enable dropped mid-period, then restarted from a full period.
    start_run(4, 0, e);
    push_tick(e + 3, 1'b0, 1'b0);
    push_tick(e + 7, 1'b0, 1'b0);
    wait_drain(100);
    step();
    step();
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    e = cyc;
    push_tick(e + 3, 1'b0, 1'b0);
    push_tick(e + 7, 1'b0, 1'b0);
    wait_drain(100);

    // Reset mid-period: no residual tick, default divisor restored.
    step();
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_outputs", {os_tick, tx_tick, rx_sample, pend}, 4'h0);
    step();
    rst_n = 1'b1;
    e = cyc;
    push_tick(e + 650, 1'b0, 1'b0);
    wait_drain(800);
    step();
    en = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_baud_tick_gen.md
Name: uart_baud_tick_gen

Overview:
- Parametrised baud timing generator for the UART. It replaces derived toggling clocks with single-cycle enable ticks in the i_Clk domain.
- A fractional divider (integer.fraction, runtime loadable) produces the oversample tick.
- A transmit bit tick and a re-alignable receive mid-bit sample tick are derived from the oversample tick.
- Feeds the UART TX and RX state machines.

Parameters:
- CLK_HZ, 100000000, system clock frequency (documentation and default-divisor derivation only).
- OVERSAMPLE, 16, oversample ticks per bit; power of 2, >= 4.
- DIV_INT_W, 16, width of the integer divisor.
- DIV_FRAC_W, 4, width of the fractional divisor (units of 1/2^DIV_FRAC_W cycle).
- RESET_DIV_INT, 651, integer divisor after reset (100 MHz / (9600*16) = 651.04).
- RESET_DIV_FRAC, 1, fractional divisor after reset.

Ports:
- i_Clk  input  1  system clock; all logic on the rising edge.
- i_Rst_n  input  1  asynchronous, active-low reset.
- i_En  input  1  generator enable.
- i_Div_Int  input  DIV_INT_W  new integer divisor, in cycles per oversample tick.
- i_Div_Frac  input  DIV_FRAC_W  new fractional divisor.
- i_Div_Load  input  1  one-cycle strobe; captures i_Div_Int and i_Div_Frac.
- i_Rx_Sync  input  1  one-cycle strobe from RX on start-bit edge detect; realigns RX phase.
- o_Os_Tick  output  1  oversample tick, one cycle wide.
- o_Tx_Tick  output  1  bit-period tick for TX, one cycle wide.
- o_Rx_Sample  output  1  mid-bit sample strobe for RX, one cycle wide.
- o_Div_Pending  output  1  a loaded divisor is waiting to be applied.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - Active divisor is RESET_DIV_INT.RESET_DIV_FRAC.
  - Fraction accumulator, TX phase and RX phase are all 0.
  - Down-counter is loaded with INT-1.
  - All outputs are 0.
  - Reset mid-operation aborts the current period with no residual tick.
- Clamp: any applied integer divisor below 2 is forced to 2.
- Disabled (i_En=0):
  - Counter is held at INT-1; accumulator, TX phase and RX phase are held at 0.
  - Tick outputs are 0.
  - A divisor load is applied on the next edge; o_Div_Pending never asserts.
- Period rule:
  - The first o_Os_Tick asserts in the INT-th consecutive cycle with i_En=1.
  - At each tick, acc_next = acc + FRAC (DIV_FRAC_W+1 bits).
  - If the carry is set, the immediately following period is INT+1 cycles; otherwise it is INT cycles.
  - acc keeps the low DIV_FRAC_W bits.
  - Average period is INT + FRAC/2^DIV_FRAC_W.
- i_En falling mid-period: the next cycle returns to the disabled state. The partial period is discarded and no tick is issued.
- TX phase:
  - Increments on each o_Os_Tick and wraps at OVERSAMPLE-1.
  - o_Tx_Tick asserts in the same cycle as the o_Os_Tick at which phase==OVERSAMPLE-1. The first o_Tx_Tick therefore coincides with the OVERSAMPLE-th oversample tick.
  - TX phase is unaffected by i_Rx_Sync.
- RX phase:
  - i_Rx_Sync clears RX phase to 0 at that edge.
  - Sync coincident with an o_Os_Tick: sync wins, and that tick is not counted.
  - o_Rx_Sample asserts with the o_Os_Tick at which RX phase==OVERSAMPLE/2-1. After that it repeats every OVERSAMPLE oversample ticks, wrapping like TX.
- Divisor load while enabled:
  - i_Div_Load captures the values into a pending register. o_Div_Pending is 1 from the next cycle.
  - At the next o_Os_Tick strictly after the load cycle, the pending value becomes active, the counter reloads with the new INT-1, acc is cleared to 0 (no carry), and o_Div_Pending drops in the cycle after that tick.
  - Load in the same cycle as a tick: that tick reloads with the old divisor; the new value applies at the following tick.
  - Load while already pending: the pending value is overwritten; one application only.
  - Phases are not reset by a load.
- Widths: counter is DIV_INT_W bits; phase counters are log2(OVERSAMPLE) bits. No arithmetic exceeds these except the accumulator carry bit.

Test Plan:
- Reset with defaults, i_En=1 from cycle 0 -> o_Os_Tick first in cycle 651. Over 16 ticks, exactly one period is 652 cycles. o_Tx_Tick first coincides with the 16th o_Os_Tick. All outputs are 0 during reset.
- Load INT=4, FRAC=8 while disabled, then enable -> o_Os_Tick periods are 4,4,5,4,5,4,5...; o_Div_Pending stays 0.
- While running at INT=4, FRAC=0, load INT=7, FRAC=0 midway through a period -> o_Div_Pending=1 until the next tick. That tick closes the 4-cycle period, subsequent periods are 7, and TX phase continues without a jump.
- i_Rx_Sync pulse at an arbitrary cycle with INT=4, FRAC=0 -> o_Rx_Sample asserts with the 8th o_Os_Tick after the sync, then every 16. Sync coincident with a tick must not count that tick.
- Load INT=0 and INT=1 -> period is 2 cycles in both cases. Load twice while pending (INT=10 then INT=12) -> only 12 is applied.
- Drop i_En mid-period and reassert, and separately assert i_Rst_n=0 mid-period -> no stray tick is issued, and the first tick after restart arrives INT cycles later.
